mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive refused Icache cycles after which Icache gets priority.
REQ-002 Parameter NUM_TAGS, default 15, is the number of live memory tags (1..15); tag 0 means none.
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-low reset; state clears on a posedge where reset==0.
REQ-005 Icache2mem_command  in  2  BUS_NONE/BUS_LOAD from the instruction cache.
REQ-006 Icache2mem_addr  in  32  Icache block address.
REQ-007 Dcache2Dmem_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from dcache_controller.
REQ-008 Dcache2Dmem_addr  in  32  Dcache block address.
REQ-009 Dcache2Dmem_data  in  64  Dcache store block.
REQ-010 mem2proc_response  in  4  memory accept tag; 0 means refused.
REQ-011 mem2proc_data  in  64  memory return block.
REQ-012 mem2proc_tag  in  4  tag of returning data; 0 means none.
REQ-013 proc2mem_command / proc2mem_addr / proc2mem_data  out  2/32/64  request to memory.
REQ-014 Imem2proc_response / Imem2proc_data / Imem2proc_tag  out  4/64/4  Icache return side.
REQ-015 Dmem2proc_response / Dmem2proc_data / Dmem2proc_tag  out  4/64/4  Dcache return side.
REQ-016 arb_error  out  1  sticky flag: a return tag had no owner.

Function
REQ-017 Grant is combinational each cycle: Dcache wins over Icache unless starve_ctr==STARVE_LIMIT, in which case Icache wins.
REQ-018 The granted source's command, addr and data drive proc2mem_*; proc2mem_data = Dcache2Dmem_data, regardless of which source is granted.
REQ-019 With no request, proc2mem_command = BUS_NONE, proc2mem_addr = 0, proc2mem_data = 0.
REQ-020 The granted source's *_response = mem2proc_response in the same cycle; the non-granted source's response = 0 (refused).
REQ-021 A source with command BUS_NONE always sees response 0.
REQ-022 starve_ctr: if Icache requests and is not granted, or is granted with mem response 0, starve_ctr increments, saturating at STARVE_LIMIT.
REQ-023 starve_ctr clears to 0 on an Icache request accepted (granted and response != 0), and also clears when Icache issues no request.
REQ-024 Owner table: NUM_TAGS entries of {valid, owner (0=I, 1=D)}.
REQ-025 On an accepted request (grant and mem2proc_response != 0), the entry at mem2proc_response is set valid, with owner = grant, on the next edge.
REQ-026 On mem2proc_tag != 0 with a valid entry, the owner's *_tag = mem2proc_tag, the other source's *_tag = 0, and the entry is cleared on the next edge.
REQ-027 On mem2proc_tag != 0 with an invalid entry, both *_tag = 0 and arb_error sets, holding until reset.
REQ-028 Imem2proc_data and Dmem2proc_data both equal mem2proc_data (broadcast); validity is carried by tag only.
REQ-029 If a return and a new accept use the same tag in one cycle, the return is routed using the pre-edge entry, and after the edge the entry holds the new owner (set wins over clear).
REQ-030 An accept to an already-valid tag overwrites the entry; this is not an error.
REQ-031 Return routing is combinational, with zero-cycle latency from mem2proc_tag to *_tag.

Reset
REQ-032 While reset==0, all owner entries are invalid, starve_ctr = 0 and arb_error = 0.
REQ-033 While reset==0, proc2mem_command = BUS_NONE and both response and tag outputs are 0, regardless of inputs.
REQ-034 Tags outstanding when reset is asserted are forgotten; their later returns set arb_error only if they arrive after reset deasserts.

Structure
REQ-035 BUS_NONE/BUS_LOAD/BUS_STORE and the owner encoding come from the shared sys_defs package.
REQ-036 The owner table is a sub-module, mem_tag_owner_table, with set port {tag, owner}, clear port {tag}, and lookup port {tag -> valid, owner}.
REQ-037 mem_arbiter contains only the grant logic, the starvation counter, muxing and arb_error.

Verification
REQ-038 Dcache LOAD and Icache LOAD in the same cycle, resp=3 -> Dcache response 3, Icache response 0; later mem2proc_tag=3 -> Dmem2proc_tag=3 and Imem2proc_tag=0.
REQ-039 Both sources request continuously for 4 cycles with resp=1..4 -> cycle 5 grants Icache, Icache response 5, and starve_ctr returns to 0.
REQ-040 Icache accepted at tag 7 while mem2proc_tag=7 returns a Dcache-owned entry in the same cycle -> Dmem2proc_tag=7 this cycle; a later return of tag 7 -> Imem2proc_tag=7.
REQ-041 mem2proc_tag=9 with no entry -> both tags 0 and arb_error=1 persisting; reset==0 for one edge -> arb_error=0.
REQ-042 Dcache STORE refused (resp=0) -> Dmem2proc_response=0 and no table update; retry next cycle with resp=2 -> entry 2 owned by D.
REQ-043 Reset asserted with tags 1 and 2 outstanding, then released; returns of tags 1 and 2 -> tags not routed and arb_error=1.

Source files
------------

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared bus command and tag owner encodings
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  localparam int TAG_W = 4;

endpackage

// File: rtl/mem_tag_owner_table.sv
// rtl/mem_tag_owner_table.sv - per-tag valid/owner record for outstanding memory requests
module mem_tag_owner_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  owner_e           set_owner,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output owner_e           lookup_owner
);

  logic [15:0] valid_q;
  logic [15:0] owner_q;
  logic        set_in_range;
  logic        lookup_in_range;

  always_comb begin
    set_in_range    = (set_tag != '0) && (32'(set_tag) <= NUM_TAGS);
    lookup_in_range = (lookup_tag != '0) && (32'(lookup_tag) <= NUM_TAGS);
    lookup_valid    = lookup_in_range && valid_q[lookup_tag];
    lookup_owner    = owner_e'(owner_q[lookup_tag]);
  end

  // Clear is applied before set so a same-tag set in the same cycle wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      if (clr_en) begin
        valid_q[clr_tag] <= 1'b0;
      end
      if (set_en && set_in_range) begin
        valid_q[set_tag] <= 1'b1;
        owner_q[set_tag] <= set_owner;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Icache/Dcache memory port arbiter with starvation guard and tag routing
module mem_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Icache2mem_command,
  input  logic [31:0] Icache2mem_addr,
  input  logic [1:0]  Dcache2Dmem_command,
  input  logic [31:0] Dcache2Dmem_addr,
  input  logic [63:0] Dcache2Dmem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  Imem2proc_response,
  output logic [63:0] Imem2proc_data,
  output logic [3:0]  Imem2proc_tag,
  output logic [3:0]  Dmem2proc_response,
  output logic [63:0] Dmem2proc_data,
  output logic [3:0]  Dmem2proc_tag,
  output logic        arb_error
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_ctr;
  logic          err_q;
  logic          i_req, d_req, starved;
  logic          grant_i, grant_d, accepted;
  logic          lookup_valid, ret_hit, ret_miss;
  owner_e        lookup_owner;

  always_comb begin
    i_req    = Icache2mem_command != BUS_NONE;
    d_req    = Dcache2Dmem_command != BUS_NONE;
    starved  = starve_ctr == CW'(STARVE_LIMIT);
    grant_i  = reset && i_req && (!d_req || starved);
    grant_d  = reset && d_req && !grant_i;
    accepted = (grant_i || grant_d) && (mem2proc_response != '0);
    ret_hit  = reset && (mem2proc_tag != '0) && lookup_valid;
    ret_miss = reset && (mem2proc_tag != '0) && !lookup_valid;
  end

  always_comb begin
    proc2mem_command   = BUS_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    Imem2proc_response = '0;
    Dmem2proc_response = '0;
    Imem2proc_tag      = '0;
    Dmem2proc_tag      = '0;
    if (grant_i) begin
      proc2mem_command   = Icache2mem_command;
      proc2mem_addr      = Icache2mem_addr;
      proc2mem_data      = Dcache2Dmem_data;
      Imem2proc_response = mem2proc_response;
    end else if (grant_d) begin
      proc2mem_command   = Dcache2Dmem_command;
      proc2mem_addr      = Dcache2Dmem_addr;
      proc2mem_data      = Dcache2Dmem_data;
      Dmem2proc_response = mem2proc_response;
    end
    if (ret_hit) begin
      if (lookup_owner == OWNER_I) Imem2proc_tag = mem2proc_tag;
      else                         Dmem2proc_tag = mem2proc_tag;
    end
  end

  assign Imem2proc_data = mem2proc_data;
  assign Dmem2proc_data = mem2proc_data;
  // Gated so the flag reads 0 throughout reset, not just after the first edge.
  assign arb_error      = err_q && reset;

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_ctr <= '0;
      err_q      <= 1'b0;
    end else begin
      if (!i_req || (grant_i && mem2proc_response != '0)) begin
        starve_ctr <= '0;
      end else if (!starved) begin
        starve_ctr <= starve_ctr + CW'(1);
      end
      if (ret_miss) begin
        err_q <= 1'b1;
      end
    end
  end

  mem_tag_owner_table #(
    .NUM_TAGS(NUM_TAGS)
  ) u_owner_table (
    .clock       (clock),
    .reset       (reset),
    .set_en      (accepted),
    .set_tag     (mem2proc_response),
    .set_owner   (grant_d ? OWNER_D : OWNER_I),
    .clr_en      (ret_hit),
    .clr_tag     (mem2proc_tag),
    .lookup_tag  (mem2proc_tag),
    .lookup_valid(lookup_valid),
    .lookup_owner(lookup_owner)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;
  import sys_defs::*;

  localparam int STARVE_LIMIT = 4;
  localparam int NUM_TAGS     = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Icache2mem_command;
  logic [31:0] Icache2mem_addr;
  logic [1:0]  Dcache2Dmem_command;
  logic [31:0] Dcache2Dmem_addr;
  logic [63:0] Dcache2Dmem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;
  logic [3:0]  Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_tag;
  logic        arb_error;

  always #5 clock = ~clock;

  mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .NUM_TAGS    (NUM_TAGS)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .Icache2mem_command (Icache2mem_command),
    .Icache2mem_addr    (Icache2mem_addr),
    .Dcache2Dmem_command(Dcache2Dmem_command),
    .Dcache2Dmem_addr   (Dcache2Dmem_addr),
    .Dcache2Dmem_data   (Dcache2Dmem_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_data      (mem2proc_data),
    .mem2proc_tag       (mem2proc_tag),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .Dmem2proc_response (Dmem2proc_response),
    .Dmem2proc_data     (Dmem2proc_data),
    .Dmem2proc_tag      (Dmem2proc_tag),
    .arb_error          (arb_error)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  iresp, dresp, itag, dtag;
    logic [63:0] idata, ddata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: owner per tag (-1 none, 0 Icache, 1 Dcache), refusal streak, sticky error.
  int owner_m[16];
  int starve_m;
  bit err_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit rst, input logic [1:0] ic, input logic [31:0] ia,
                       input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [3:0] rsp, input logic [3:0] mt);
    exp_t e;
    bit ir, dr, gi, gd;
    logic [63:0] md;
    md = {$urandom, $urandom};
    @(posedge clock);
    #1;
    reset = rst; Icache2mem_command = ic; Icache2mem_addr = ia;
    Dcache2Dmem_command = dc; Dcache2Dmem_addr = da; Dcache2Dmem_data = dd;
    mem2proc_response = rsp; mem2proc_data = md; mem2proc_tag = mt;
    e = '{cmd: BUS_NONE, addr: '0, data: '0, iresp: '0, dresp: '0, itag: '0, dtag: '0,
          idata: md, ddata: md, err: 1'b0};
    if (!rst) begin
      q.push_back(e);
      foreach (owner_m[i]) owner_m[i] = -1;
      starve_m = 0;
      err_m = 0;
      return;
    end
    ir = ic != BUS_NONE;
    dr = dc != BUS_NONE;
    gi = ir && (!dr || starve_m == STARVE_LIMIT);
    gd = dr && !gi;
    if (gi) begin
      e.cmd = ic; e.addr = ia; e.data = dd; e.iresp = rsp;
    end else if (gd) begin
      e.cmd = dc; e.addr = da; e.data = dd; e.dresp = rsp;
    end
    e.err = err_m;
    if (mt != 0) begin
      if (owner_m[mt] == 0)      e.itag = mt;
      else if (owner_m[mt] == 1) e.dtag = mt;
      else                       err_m = 1;
      owner_m[mt] = -1;
    end
    if ((gi || gd) && rsp != 0) owner_m[rsp] = gd ? 1 : 0;
    if (!ir || (gi && rsp != 0)) starve_m = 0;
    else if (starve_m < STARVE_LIMIT) starve_m++;
    q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] mt);
    cycle(1, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, mt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("proc2mem_command", 64'(proc2mem_command), 64'(e.cmd));
        check("proc2mem_addr", 64'(proc2mem_addr), 64'(e.addr));
        check("proc2mem_data", proc2mem_data, e.data);
        check("Imem2proc_response", 64'(Imem2proc_response), 64'(e.iresp));
        check("Dmem2proc_response", 64'(Dmem2proc_response), 64'(e.dresp));
        check("Imem2proc_tag", 64'(Imem2proc_tag), 64'(e.itag));
        check("Dmem2proc_tag", 64'(Dmem2proc_tag), 64'(e.dtag));
        check("Imem2proc_data", Imem2proc_data, e.idata);
        check("Dmem2proc_data", Dmem2proc_data, e.ddata);
        check("arb_error", 64'(arb_error), 64'(e.err));
      end
    end
  end

  function automatic logic [3:0] pick_tag();
    int live[$];
    for (int t = 1; t < 16; t++) if (owner_m[t] >= 0) live.push_back(t);
    if (live.size() > 0 && $urandom_range(0, 2) != 0)
      return 4'(live[$urandom_range(0, live.size() - 1)]);
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin : stim
    logic [1:0] icmd, dcmd;
    logic [3:0] rsp;
    foreach (owner_m[i]) owner_m[i] = -1;
    starve_m = 0; err_m = 0;
    reset = 0; Icache2mem_command = BUS_NONE; Icache2mem_addr = '0;
    Dcache2Dmem_command = BUS_NONE; Dcache2Dmem_addr = '0; Dcache2Dmem_data = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;

    // Reset with active inputs: outputs must stay quiet.
    cycle(0, BUS_LOAD, 32'h100, BUS_STORE, 32'h200, 64'hA5, 4'd5, 4'd3);
    cycle(0, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0);

    // Simultaneous loads: Dcache wins, then tag 3 returns to Dcache.
    cycle(1, BUS_LOAD, 32'h1000, BUS_LOAD, 32'h2000, 64'h11, 4'd3, 4'd0);
    idle(4'd0);
    idle(4'd3);

    // Continuous contention: fifth cycle goes to Icache, then Dcache wins again.
    for (int r = 1; r <= 6; r++)
      cycle(1, BUS_LOAD, 32'h3000 + 32'(r), BUS_LOAD, 32'h4000 + 32'(r), 64'(r), 4'(r), 4'd0);
    for (int t = 1; t <= 6; t++) idle(4'(t));

    // Same-cycle return and re-accept of tag 7.
    cycle(1, BUS_NONE, 32'h0, BUS_LOAD, 32'h5000, 64'h22, 4'd7, 4'd0);
    cycle(1, BUS_LOAD, 32'h6000, BUS_NONE, 32'h0, 64'h33, 4'd7, 4'd7);
    idle(4'd0);
    idle(4'd7);

    // Orphan return sets sticky error; one reset edge clears it.
    idle(4'd9);
    idle(4'd0);
    idle(4'd0);
    cycle(0, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0);
    idle(4'd0);

    // Refused store, then retry accepted at tag 2.
    cycle(1, BUS_NONE, 32'h0, BUS_STORE, 32'h7000, 64'h44, 4'd0, 4'd0);
    cycle(1, BUS_NONE, 32'h0, BUS_STORE, 32'h7000, 64'h44, 4'd2, 4'd0);
    idle(4'd2);

    // Outstanding tags forgotten across reset.
    cycle(1, BUS_NONE, 32'h0, BUS_LOAD, 32'h8000, 64'h55, 4'd1, 4'd0);
    cycle(1, BUS_LOAD, 32'h9000, BUS_NONE, 32'h0, 64'h66, 4'd2, 4'd0);
    cycle(0, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0);
    idle(4'd1);
    idle(4'd2);
    idle(4'd0);
    cycle(0, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0);

    for (int n = 0; n < 600; n++) begin
      icmd = ($urandom_range(0, 3) != 0) ? BUS_LOAD : BUS_NONE;
      case ($urandom_range(0, 3))
        0:       dcmd = BUS_NONE;
        1, 2:    dcmd = BUS_LOAD;
        default: dcmd = BUS_STORE;
      endcase
      rsp = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
      cycle(($urandom_range(0, 59) != 0), icmd, $urandom, dcmd, $urandom,
            {$urandom, $urandom}, rsp, pick_tag());
    end

    @(negedge clock);
    #1;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
